// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, datapath width and the multiply
// controller's state encoding.
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Request/response bundle between a multiply requester and alu_mul_seq.
interface alu_mul_seq_if import alu_pkg::*; ();

    logic            start;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] product;

    modport master (
        output start, op_a, op_b,
        input  busy, done, product
    );

    modport slave (
        input  start, op_a, op_b,
        output busy, done, product
    );

endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier that borrows the shared ALU adder to build
// the low XLEN bits of op_a*op_b, one multiplier bit per RUN cycle.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter logic [3:0] CTL_ADD  = ALU_ADD,
    parameter logic [3:0] CTL_IDLE = ALU_AND
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_mul_seq_if.slave    req,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctl,
    input  logic [XLEN-1:0] alu_result
);

    mul_state_e      state_q, state_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] product_q, product_d;

    logic            accept;
    logic            last_step;
    logic [XLEN-1:0] acc_step;

    // start is only honoured outside RUN; a request during RUN is dropped
    assign accept    = req.start && (state_q != ST_RUN);
    assign last_step = (mplier_q[XLEN-1:1] == '0);
    assign acc_step  = mplier_q[0] ? alu_result : acc_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_d = (req.op_b != '0) ? ST_RUN : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_step) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        product_d = product_q;
        if (accept) begin
            acc_d    = '0;
            mcand_d  = req.op_a;
            mplier_d = req.op_b;
            if (req.op_b == '0) begin
                product_d = '0;
            end
        end else if (state_q == ST_RUN) begin
            acc_d    = acc_step;
            mcand_d  = {mcand_q[XLEN-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[XLEN-1:1]};
            if (last_step) begin
                product_d = acc_step;
            end
        end
    end

    // ALU ports come only from registers, never from start or the operands
    always_comb begin
        req.busy    = (state_q == ST_RUN);
        req.done    = (state_q == ST_DONE);
        req.product = product_q;
        alu_a       = acc_q;
        alu_b       = mcand_q;
        alu_ctl     = (state_q == ST_RUN) ? CTL_ADD : CTL_IDLE;
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural stand-in for the shared ALU.
module tb_alu_mul_seq;
    import alu_pkg::*;

    logic            clk;
    logic            rst_n;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_ctl;
    logic [XLEN-1:0] alu_result;

    int checks = 0;
    int errors = 0;

    alu_mul_seq_if mul_if ();

    alu_mul_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (mul_if),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctl    (alu_ctl),
        .alu_result (alu_result)
    );

    always_comb begin
        case (alu_ctl)
            ALU_AND: alu_result = alu_a & alu_b;
            ALU_OR:  alu_result = alu_a | alu_b;
            ALU_ADD: alu_result = alu_a + alu_b;
            ALU_SUB: alu_result = alu_a - alu_b;
            ALU_SLT: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            ALU_NOR: alu_result = ~(alu_a | alu_b);
            default: alu_result = '0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts busy cycles from the current cycle until done, then checks
    // the busy-cycle count, the product, and that done lasts one cycle.
    task automatic wait_done(input string tag, input int exp_busy, input logic [31:0] exp_prod,
                             input bool_dummy_unused = 0);
        int n_busy = 0;
        int guard  = 0;
        while (!mul_if.done && guard < 40) begin
            if (mul_if.busy) begin
                n_busy++;
                if (alu_ctl !== ALU_ADD) begin
                    check({tag, "_ctl_busy"}, {28'd0, alu_ctl}, {28'd0, ALU_ADD});
                end
            end
            guard++;
            tick();
        end
        check({tag, "_done_seen"}, {31'd0, mul_if.done}, 32'd1);
        check({tag, "_busy_cycles"}, n_busy, exp_busy);
        check({tag, "_product"}, mul_if.product, exp_prod);
        check({tag, "_ctl_done"}, {28'd0, alu_ctl}, {28'd0, ALU_AND});
        $display("op %s: busy=%0d product=0x%08h", tag, n_busy, mul_if.product);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int exp_busy, input logic [31:0] exp_prod);
        mul_if.start = 1'b1;
        mul_if.op_a  = a;
        mul_if.op_b  = b;
        tick();
        mul_if.start = 1'b0;
        wait_done(tag, exp_busy, exp_prod);
        tick();
        check({tag, "_done_pulse"}, {31'd0, mul_if.done}, 32'd0);
        check({tag, "_hold"}, mul_if.product, exp_prod);
    endtask

    initial begin
        rst_n        = 1'b0;
        mul_if.start = 1'b1;
        mul_if.op_a  = 32'd7;
        mul_if.op_b  = 32'd6;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_busy", {31'd0, mul_if.busy}, 32'd0);
            check("rst_done", {31'd0, mul_if.done}, 32'd0);
            check("rst_product", mul_if.product, 32'd0);
            check("rst_ctl", {28'd0, alu_ctl}, 32'd0);
            check("rst_alu_a", alu_a, 32'd0);
            check("rst_alu_b", alu_b, 32'd0);
        end
        mul_if.start = 1'b0;
        rst_n = 1'b1;
        tick();

        // basic and boundary operands
        run_op("7x6", 32'd7, 32'd6, 3, 32'd42);
        run_op("b_zero", 32'hFFFF_FFFF, 32'd0, 0, 32'd0);
        run_op("msb", 32'hFFFF_FFFF, 32'h8000_0000, 32, 32'h8000_0000);
        run_op("neg1x3", 32'hFFFF_FFFF, 32'd3, 2, 32'hFFFF_FFFD);
        run_op("wrap", 32'h0001_0000, 32'h0001_0000, 17, 32'd0);

        // start during RUN with different operands is dropped
        mul_if.start = 1'b1;
        mul_if.op_a  = 32'd7;
        mul_if.op_b  = 32'd6;
        tick();
        mul_if.op_a = 32'd100;
        mul_if.op_b = 32'd100;
        tick();
        mul_if.start = 1'b0;
        wait_done("ign_run", 2, 32'd42);
        tick();
        check("ign_idle_busy", {31'd0, mul_if.busy}, 32'd0);

        // back-to-back: start held through the DONE cycle
        mul_if.start = 1'b1;
        mul_if.op_a  = 32'd5;
        mul_if.op_b  = 32'd3;
        tick();
        mul_if.start = 1'b0;
        wait_done("b2b_first", 2, 32'd15);
        mul_if.start = 1'b1;
        mul_if.op_a  = 32'd9;
        mul_if.op_b  = 32'd9;
        tick();
        mul_if.start = 1'b0;
        check("b2b_no_bubble", {31'd0, mul_if.busy}, 32'd1);
        wait_done("b2b_second", 4, 32'd81);
        tick();

        // abort during the 5th RUN cycle
        mul_if.start = 1'b1;
        mul_if.op_a  = 32'h1234;
        mul_if.op_b  = 32'hFFFF;
        tick();
        mul_if.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("abort_busy5", {31'd0, mul_if.busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_product", mul_if.product, 32'd0);
        check("abort_busy", {31'd0, mul_if.busy}, 32'd0);
        begin
            int seen_done = 0;
            for (int i = 0; i < 20; i++) begin
                if (mul_if.done) seen_done++;
                tick();
            end
            check("abort_no_done", seen_done, 0);
        end
        run_op("after_abort", 32'd3, 32'd5, 3, 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
